// File: rtl/freq_meter.sv
// Half-period meter for toggle-divider square waves: counts clk cycles between sig_in edges.
// Optional FREQ_METER_SYNC_EN adds a two-flop input synchronizer for asynchronous sources.
module freq_meter #(
  parameter int unsigned WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] half_period,
  output logic             valid,
  output logic             locked,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    ARM,
    MEASURE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] half_period_q;
  logic             have_prev_q;
  logic             valid_q;
  logic             locked_q;
  logic             stalled_q;
  logic             sig_s;
  logic             sig_d_q;
  logic             sig_edge;

`ifdef FREQ_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], sig_in};
    end
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = sig_in;
`endif

  // Both polarities of the conditioned input count as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d_q <= 1'b0;
    end else begin
      sig_d_q <= sig_s;
    end
  end

  assign sig_edge = sig_s ^ sig_d_q;
  assign cnt_d    = cnt_q + WIDTH'(1);

  // Measurement FSM; an edge takes priority over saturation in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARM;
      cnt_q         <= '0;
      half_period_q <= '0;
      have_prev_q   <= 1'b0;
      valid_q       <= 1'b0;
      locked_q      <= 1'b0;
      stalled_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!en) begin
        state_q     <= ARM;
        cnt_q       <= '0;
        locked_q    <= 1'b0;
        have_prev_q <= 1'b0;
      end else begin
        case (state_q)
          ARM: begin
            if (sig_edge) begin
              cnt_q   <= '0;
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            if (sig_edge) begin
              half_period_q <= cnt_q;
              valid_q       <= 1'b1;
              cnt_q         <= '0;
              stalled_q     <= 1'b0;
              locked_q      <= have_prev_q && (cnt_q == half_period_q);
              have_prev_q   <= 1'b1;
            end else if (cnt_q == CNT_MAX) begin
              stalled_q   <= 1'b1;
              locked_q    <= 1'b0;
              have_prev_q <= 1'b0;
              cnt_q       <= '0;
              state_q     <= ARM;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: begin
            state_q <= ARM;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign half_period = half_period_q;
  assign valid       = valid_q;
  assign locked      = locked_q;
  assign stalled     = stalled_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed self-checking bench for freq_meter (WIDTH=8) driven by a programmable toggle source.
module tb_freq_meter;

  localparam int unsigned WIDTH = 8;
`ifdef FREQ_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic             sig_in;
  logic [WIDTH-1:0] half_period;
  logic             valid;
  logic             locked;
  logic             stalled;

  int n_cmp;
  int n_err;
  int cyc;
  int per;
  int per_next;
  int ph;
  int last_tog;

  freq_meter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .half_period(half_period),
    .valid      (valid),
    .locked     (locked),
    .stalled    (stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: outputs are sampled 1ns after the edge, then the toggle source advances.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (per > 0) begin
      ph++;
      if (ph >= per) begin
        sig_in   = ~sig_in;
        ph       = 0;
        per      = per_next;
        last_tog = cyc;
      end
    end
  endtask

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!valid && n < budget);
    if (!valid) check(tag, 32'(valid), 32'd1);
  endtask

  int n;

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    per = 1; per_next = 1; ph = 0; last_tog = 0;
    rst = 1'b1; en = 1'b1; sig_in = 1'b0;

    // Reset held with a toggling input
    for (int i = 0; i < 8; i++) begin
      step();
      check("rst_hp", 32'(half_period), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_stalled", 32'(stalled), 32'd0);
    end
    per = 0; sig_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rel_valid", 32'(valid), 32'd0);

    // Steady L=4
    per = 5; per_next = 5; ph = 0;
    wait_valid("l4_first_to", 40, n);
    check("l4_first_hp", 32'(half_period), 32'd4);
    check("l4_first_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 3; i++) begin
      wait_valid("l4_to", 20, n);
      check("l4_spacing", 32'(n), 32'd5);
      check("l4_hp", 32'(half_period), 32'd4);
      check("l4_locked", 32'(locked), 32'd1);
    end

    // Ratio change to L=9
    per_next = 10;
    wait_valid("rc_to", 20, n);
    check("rc_old_hp", 32'(half_period), 32'd4);
    wait_valid("rc_to", 20, n);
    check("rc_new_hp", 32'(half_period), 32'd9);
    check("rc_new_locked", 32'(locked), 32'd0);
    check("rc_new_spacing", 32'(n), 32'd10);
    wait_valid("rc_to", 20, n);
    check("rc_relock_hp", 32'(half_period), 32'd9);
    check("rc_relock_locked", 32'(locked), 32'd1);

    // Timeout after the input stops
    per_next = 0;
    wait_valid("to_last_to", 20, n);
    check("to_last_hp", 32'(half_period), 32'd9);
    check("to_last_locked", 32'(locked), 32'd1);
    n = 0;
    while (!stalled && n < 400) begin
      step();
      n++;
    end
    check("to_stalled", 32'(stalled), 32'd1);
    check("to_delay", 32'(cyc - last_tog), 32'(257 + LAT));
    check("to_locked", 32'(locked), 32'd0);
    check("to_hp_hold", 32'(half_period), 32'd9);
    check("to_valid", 32'(valid), 32'd0);

    // Resume at L=3
    per = 4; per_next = 4; ph = 0;
    repeat (3) step();
    check("rs_stall_hold", 32'(stalled), 32'd1);
    wait_valid("rs_to", 30, n);
    check("rs_hp", 32'(half_period), 32'd3);
    check("rs_stalled", 32'(stalled), 32'd0);
    check("rs_locked", 32'(locked), 32'd0);

    // Fastest input, L=0
    per_next = 1;
    repeat (20) step();
    for (int i = 0; i < 8; i++) begin
      step();
      check("l0_valid", 32'(valid), 32'd1);
      check("l0_hp", 32'(half_period), 32'd0);
      check("l0_locked", 32'(locked), 32'd1);
    end

    // Settle at L=5
    per_next = 6;
    repeat (30) step();
    wait_valid("l5_to", 20, n);
    check("l5_hp", 32'(half_period), 32'd5);
    check("l5_locked", 32'(locked), 32'd1);

    // Reset two cycles after an edge
    step();
    step();
    per = 0; sig_in = 1'b0; rst = 1'b1;
    step();
    check("mr_hp", 32'(half_period), 32'd0);
    check("mr_valid", 32'(valid), 32'd0);
    check("mr_locked", 32'(locked), 32'd0);
    rst = 1'b0; per = 6; per_next = 6; ph = 0;
    wait_valid("mr_to", 40, n);
    check("mr_first_delay", 32'(n), 32'(13 + LAT));
    check("mr_first_hp", 32'(half_period), 32'd5);
    check("mr_first_locked", 32'(locked), 32'd0);
    wait_valid("mr_to", 20, n);
    check("mr_relock", 32'(locked), 32'd1);

    // Disable for 10 cycles
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("dis_valid", 32'(valid), 32'd0);
      check("dis_locked", 32'(locked), 32'd0);
    end
    check("dis_hp_hold", 32'(half_period), 32'd5);
    en = 1'b1;
    wait_valid("en_to", 30, n);
    check("en_hp", 32'(half_period), 32'd5);
    check("en_locked", 32'(locked), 32'd0);
    wait_valid("en_to", 20, n);
    check("en_spacing", 32'(n), 32'd6);
    check("en_relock", 32'(locked), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the half-period of a square wave made by a toggle-style frequency divider. It counts `clk` cycles between consecutive edges of `sig_in` and reports the count as `half_period`, in the same encoding as the divider's `limit` input: a wave that toggles every L+1 clocks reads back as L. The block sits on the receive side of divided-clock links and on self-check paths that confirm a programmed divider ratio.

## Interface
- `WIDTH`, default 27: counter and result width, matching the divider's `limit` width.
- `clk` input 1: single clock; every register updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: measurement enable; when low, the block holds in ARM.
- `sig_in` input 1: the square wave being measured.
- `half_period` output WIDTH: last completed measurement; reset value 0.
- `valid` output 1: one-cycle pulse when `half_period` updates; reset value 0.
- `locked` output 1: high while the two most recent measurements are equal; reset value 0.
- `stalled` output 1: sticky timeout flag, cleared by the next `valid`; reset value 0.

## Operation
- **Input conditioning:** `sig_s` is the conditioned input (see Configuration). `sig_d` is `sig_s` delayed by one register. `edge` = `sig_s ^ sig_d`. Both polarities count.
- **Internal state:** counter `cnt[WIDTH-1:0]`, flag `have_prev`, two-state FSM {ARM, MEASURE}.
- **Reset:** state=ARM, `cnt`=0, `have_prev`=0, `sig_d`=0, synchronizer flops=0, all outputs 0.
- **`en` low:** state←ARM, `cnt`←0, `valid`←0, `locked`←0, `have_prev`←0. `half_period` and `stalled` hold.
- **ARM:**
  - `edge` → `cnt`←0, go to MEASURE.
  - No `valid` is produced here; the first edge only arms the counter.
- **MEASURE, `edge`=1:**
  - `half_period`←`cnt`, `valid`←1, `cnt`←0, `stalled`←0.
  - `locked`←(`have_prev` && `cnt`==`half_period`).
  - `have_prev`←1. Stay in MEASURE.
- **MEASURE, no edge, `cnt` < 2^WIDTH−1:** `cnt`←`cnt`+1.
- **MEASURE, no edge, `cnt` == 2^WIDTH−1 (timeout):**
  - `stalled`←1, `locked`←0, `have_prev`←0, `cnt`←0, go to ARM.
  - `half_period` holds.
- **Edge and saturation in the same cycle:** the edge wins, giving `half_period` = 2^WIDTH−1 and `valid`=1.
- **Counter behaviour:** `cnt` never wraps. Arithmetic is unsigned, WIDTH bits.
- `valid` is 0 in every cycle not listed above.

## Timing
- Edge spacing:
  - Edges of `sig_s` spaced N cycles apart give `half_period` = N−1.
  - A divider with `limit`=L gives L.
  - L=0 (edge every cycle) gives 0.
- Latency from a `sig_in` transition (sampled at rising edge k) to `valid` high:
  - with the synchronizer: visible after edge k+2;
  - without it: visible after edge k.
- After reset or re-arm:
  - the first `valid` comes on the 2nd edge;
  - `locked` can first assert on the 3rd edge.
- Reset takes priority over every event in the same cycle. Reset mid-measurement discards the partial count.
- `valid` is never high for two consecutive cycles unless `sig_s` toggles every cycle.

## Configuration
- **`FREQ_METER_SYNC_EN` defined:** `sig_s` is `sig_in` passed through two flip-flops (metastability protection for an asynchronous source); latency as above.
- **`FREQ_METER_SYNC_EN` undefined:** `sig_s` = `sig_in` directly. `sig_in` must then be synchronous to `clk`. Measured values are identical; only latency changes.

## Test plan
- **Reset values:** assert `rst` with `sig_in` toggling → `half_period`=0, `valid`=0, `locked`=0, `stalled`=0 throughout; no `valid` in the first cycle after release.
- **Steady L=4:** drive `sig_in` toggling every 5 cycles, `en`=1 → `valid` pulses every 5 cycles with `half_period`=4; `locked`=1 from the second `valid` onward.
- **Fastest input, L=0:** `sig_in` toggles every cycle → `half_period`=0, `valid` high continuously after arming, `locked`=1.
- **Ratio change:** switch from L=4 to L=9 mid-stream → first new `valid` reports 9 with `locked`=0; the next 9 sets `locked`=1.
- **Timeout (WIDTH=8):** stop toggling after lock → `stalled`=1 and `locked`=0 exactly 256 cycles after the last edge, `half_period` holds; resume at L=3 → `stalled` clears on the next `valid`, which reports 3.
- **Reset and disable mid-measurement:** pulse `rst` 2 cycles after an edge → the partial count is discarded and the next report needs a fresh arming edge; `en` low for 10 cycles → `locked`=0 and the block re-arms.
